pkt_buf_reader: RTL and testbench



---
 rtl/pkt_buf_reader.sv | 194 +++++++++++++++++++
 tb/tb_pkt_buf_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_buf_reader.sv
// pkt_buf_reader: dequeue engine of the shared packet buffer.
// Takes a descriptor (head address, length in words) and follows the packet's
// word chain through the address manager. Each word is read from the data RAM
// and released to the free list. The words leave as an AXI4-Stream packet.
// A 2-entry output FIFO with credit-based issue absorbs backpressure.
// Optional build macro: PKT_RD_STATS_EN adds the stat_pkts/stat_words counters.
//
// state  | meaning
// IDLE   | ready for a descriptor; len=0 descriptors are dropped here
// FIRST  | issue the head word and the first-word strobe to the address manager
// LINK   | address manager relink cycle, no strobes
// STREAM | issue one chained word per cycle while output credit remains
// DRAIN  | wait for the FIFO to empty and the last read to land
module pkt_buf_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_desc_valid,
    output logic                  s_desc_ready,
    input  logic [ADDR_WIDTH-1:0] s_desc_head,
    input  logic [LEN_WIDTH-1:0]  s_desc_len,
    output logic                  am_rd_en,
    output logic                  am_first_word_en,
    output logic [ADDR_WIDTH-1:0] am_rd_addr,
    input  logic [ADDR_WIDTH-1:0] am_rd_next_addr,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
`ifdef PKT_RD_STATS_EN
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_words,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_LINK,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] head_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  pend_q;
    logic                  pend_last_q;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wptr_q;
    logic                  rptr_q;
    logic [1:0]            occ_q;

    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;
    logic [2:0]            used_c;
    logic                  credit_ok;

    assign s_desc_ready  = rstn && (state == ST_IDLE);
    assign accept        = s_desc_valid && s_desc_ready;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_last[rptr_q];

    assign push = pend_q;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // A beat leaving this cycle frees its slot before the issued read can
    // land (one cycle later), so counting the pop keeps full throughput
    // while the FIFO can still never exceed two entries.
    assign used_c    = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign credit_ok = (used_c <= 3'd1);

    assign am_rd_en   = issue;
    assign buf_rd_en  = issue;
    assign am_rd_addr = head_q;
    assign busy       = (state != ST_IDLE) || m_axis_tvalid;

    // Next-state and read-strobe decode.
    always_comb begin
        state_nxt        = state;
        issue            = 1'b0;
        issue_last       = 1'b0;
        am_first_word_en = 1'b0;
        buf_rd_addr      = '0;
        case (state)
            ST_IDLE: begin
                if (accept && (s_desc_len != '0)) begin
                    state_nxt = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (credit_ok) begin
                    issue            = 1'b1;
                    am_first_word_en = 1'b1;
                    buf_rd_addr      = head_q;
                    issue_last       = (len_q == LEN_WIDTH'(1));
                    state_nxt        = issue_last ? ST_DRAIN : ST_LINK;
                end
            end
            ST_LINK: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    buf_rd_addr = am_rd_next_addr;
                    issue_last  = ((cnt_q + LEN_WIDTH'(1)) == len_q);
                    if (issue_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!m_axis_tvalid && !pend_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, descriptor, word counter, in-flight tracking and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            head_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                head_q <= s_desc_head;
                len_q  <= s_desc_len;
                cnt_q  <= '0;
            end else if (issue) begin
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
            pend_q      <= issue;
            pend_last_q <= issue_last;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Capture RAM data one cycle after each read; tlast was tagged at issue.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr_q] <= buf_rd_data;
            fifo_last[wptr_q] <= pend_last_q;
        end
    end

`ifdef PKT_RD_STATS_EN
    // Count accepted beats and packets; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_pkts  <= '0;
            stat_words <= '0;
        end else if (pop) begin
            stat_words <= stat_words + 32'd1;
            if (m_axis_tlast) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_buf_reader.sv
// Testbench for pkt_buf_reader: table of single-descriptor packets plus
// hand-written back-to-back and mid-packet reset sequences.
module tb_pkt_buf_reader;

    logic         clk;
    logic         rstn;
    logic         s_desc_valid;
    logic         s_desc_ready;
    logic [11:0]  s_desc_head;
    logic [11:0]  s_desc_len;
    logic         am_rd_en;
    logic         am_first_word_en;
    logic [11:0]  am_rd_addr;
    logic [11:0]  am_rd_next_addr;
    logic         buf_rd_en;
    logic [11:0]  buf_rd_addr;
    logic [255:0] buf_rd_data;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         busy;
`ifdef PKT_RD_STATS_EN
    logic [31:0]  stat_pkts;
    logic [31:0]  stat_words;
`endif

    pkt_buf_reader #(.ADDR_WIDTH(12), .LEN_WIDTH(12), .DATA_WIDTH(256)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .s_desc_valid     (s_desc_valid),
        .s_desc_ready     (s_desc_ready),
        .s_desc_head      (s_desc_head),
        .s_desc_len       (s_desc_len),
        .am_rd_en         (am_rd_en),
        .am_first_word_en (am_first_word_en),
        .am_rd_addr       (am_rd_addr),
        .am_rd_next_addr  (am_rd_next_addr),
        .buf_rd_en        (buf_rd_en),
        .buf_rd_addr      (buf_rd_addr),
        .buf_rd_data      (buf_rd_data),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
`ifdef PKT_RD_STATS_EN
        .stat_pkts        (stat_pkts),
        .stat_words       (stat_words),
`endif
        .busy             (busy)
    );

    typedef struct {
        logic [11:0]      head;
        logic [11:0]      len;
        logic [3:0]       pat;
        logic [0:7][11:0] addrs;
        bit               full_rate;
    } vec_t;

    vec_t        vecs [7];
    logic [11:0] bb_addr [5];
    logic [11:0] link [4096];
    logic [11:0] cur;
    logic [3:0]  pat;
    int          cyc;
    int          n_checks;
    int          n_pass;

    // monitor-owned state
    logic [11:0]  rd_addr_q [$];
    int           rd_cyc_q [$];
    logic [255:0] beat_data_q [$];
    bit           beat_last_q [$];
    int           beat_cyc_q [$];
    int           acc_q [$];
    int           n_amrd, n_first, hold_err;
    int           tot_beats, tot_pkts;
    int           clr_gen, seen_gen;
    bit           prev_stall;
    logic [255:0] prev_data;
    logic         prev_last;

    function automatic logic [255:0] mk_data(input logic [11:0] a);
        return {16{4'hC, a}};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // address manager and data RAM models
    assign am_rd_next_addr = link[cur];
    always @(posedge clk) begin
        if (am_rd_en) cur <= buf_rd_addr;
        if (buf_rd_en) buf_rd_data <= mk_data(buf_rd_addr);
    end

    // tready follows the current 4-cycle pattern
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = pat[cyc % 4];
        end
    end

    // monitor: samples on the falling edge, away from the active edge
    initial begin
        seen_gen = 0; n_amrd = 0; n_first = 0; hold_err = 0;
        tot_beats = 0; tot_pkts = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (seen_gen != clr_gen) begin
                seen_gen = clr_gen;
                rd_addr_q.delete(); rd_cyc_q.delete(); beat_data_q.delete();
                beat_last_q.delete(); beat_cyc_q.delete(); acc_q.delete();
                n_amrd = 0; n_first = 0; hold_err = 0;
            end
            if (!rstn) begin
                prev_stall = 0;
            end else begin
                if (s_desc_valid && s_desc_ready) acc_q.push_back(cyc);
                if (am_rd_en) n_amrd++;
                if (am_first_word_en) n_first++;
                if (buf_rd_en) begin
                    rd_addr_q.push_back(buf_rd_addr);
                    rd_cyc_q.push_back(cyc);
                end
                if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
                    hold_err++;
                if (m_axis_tvalid && m_axis_tready) begin
                    beat_data_q.push_back(m_axis_tdata);
                    beat_last_q.push_back(m_axis_tlast);
                    beat_cyc_q.push_back(cyc);
                    tot_beats++;
                    if (m_axis_tlast) tot_pkts++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_data(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || n < 4) && n < 400);
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        clr_gen++;
        pat          = v.pat;
        s_desc_valid = 1'b1;
        s_desc_head  = v.head;
        s_desc_len   = v.len;
        @(posedge clk);
        #1;
        s_desc_valid = 1'b0;
        wait_idle(nm);
        chk({nm, "_accepts"}, acc_q.size(), 1);
        chk({nm, "_am_rd_cnt"}, n_amrd, v.len);
        chk({nm, "_first_cnt"}, n_first, (v.len != 0) ? 1 : 0);
        chk({nm, "_rd_cnt"}, rd_addr_q.size(), v.len);
        for (int k = 0; k < int'(v.len) && k < rd_addr_q.size(); k++)
            chk($sformatf("%s_addr%0d", nm, k), rd_addr_q[k], v.addrs[k]);
        chk({nm, "_beats"}, beat_data_q.size(), v.len);
        for (int k = 0; k < int'(v.len) && k < beat_data_q.size(); k++) begin
            chk_data($sformatf("%s_data%0d", nm, k), beat_data_q[k], mk_data(v.addrs[k]));
            chk($sformatf("%s_last%0d", nm, k), beat_last_q[k], (k == int'(v.len) - 1) ? 1 : 0);
        end
        chk({nm, "_hold"}, hold_err, 0);
        if (v.full_rate && beat_cyc_q.size() > 0 && acc_q.size() > 0) begin
            chk({nm, "_latency"}, beat_cyc_q[0] - acc_q[0], 3);
            for (int k = 1; k < rd_cyc_q.size(); k++)
                chk($sformatf("%s_rdgap%0d", nm, k), rd_cyc_q[k] - rd_cyc_q[k-1], (k == 1) ? 2 : 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int base_beats;
        int base_pkts;
        n_checks = 0; n_pass = 0; clr_gen = 0; cur = '0;
        for (int a = 0; a < 4096; a++) link[a] = 12'(a + 1);
        link[0] = 12'd7; link[7] = 12'd3; link[3] = 12'd9;

        vecs[0] = '{head: 12'd5,  len: 12'd1, pat: 4'b1111, addrs: '0, full_rate: 1'b1};
        vecs[0].addrs[0] = 12'd5;
        vecs[1] = '{head: 12'd0,  len: 12'd4, pat: 4'b1111, addrs: '0, full_rate: 1'b1};
        vecs[1].addrs[0] = 12'd0; vecs[1].addrs[1] = 12'd7; vecs[1].addrs[2] = 12'd3; vecs[1].addrs[3] = 12'd9;
        vecs[2] = vecs[1];
        vecs[2].pat = 4'b1001; vecs[2].full_rate = 1'b0;
        vecs[3] = '{head: 12'd12, len: 12'd0, pat: 4'b1111, addrs: '0, full_rate: 1'b0};
        vecs[4] = '{head: 12'd2,  len: 12'd1, pat: 4'b1111, addrs: '0, full_rate: 1'b1};
        vecs[4].addrs[0] = 12'd2;
        vecs[5] = '{head: 12'd3,  len: 12'd3, pat: 4'b0101, addrs: '0, full_rate: 1'b0};
        vecs[5].addrs[0] = 12'd3; vecs[5].addrs[1] = 12'd9; vecs[5].addrs[2] = 12'd10;
        vecs[6] = '{head: 12'd7,  len: 12'd2, pat: 4'b0011, addrs: '0, full_rate: 1'b0};
        vecs[6].addrs[0] = 12'd7; vecs[6].addrs[1] = 12'd3;
        bb_addr[0] = 12'd0; bb_addr[1] = 12'd7; bb_addr[2] = 12'd3; bb_addr[3] = 12'd7; bb_addr[4] = 12'd3;

        // reset
        pat = 4'b1111;
        rstn = 1'b0; s_desc_valid = 1'b0; s_desc_head = '0; s_desc_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", s_desc_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_ready", s_desc_ready, 1);
        chk("rel_busy", busy, 0);
        chk("rel_tvalid", m_axis_tvalid, 0);
        chk("rel_tlast", m_axis_tlast, 0);
        chk("rel_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
        chk("rel_strobes", {am_rd_en, am_first_word_en, buf_rd_en}, 0);
`ifdef PKT_RD_STATS_EN
        chk("rel_stat_words", stat_words, 0);
        chk("rel_stat_pkts", stat_pkts, 0);
`endif

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // back-to-back descriptors: len=3 then len=2
        @(posedge clk);
        #1;
        clr_gen++;
        pat = 4'b1111;
        s_desc_valid = 1'b1; s_desc_head = 12'd0; s_desc_len = 12'd3;
        @(posedge clk);
        #1;
        s_desc_head = 12'd7; s_desc_len = 12'd2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acc_q.size() < 2 && n < 100);
        chk("b2b_second_accept", acc_q.size(), 2);
        @(posedge clk);
        #1;
        s_desc_valid = 1'b0;
        wait_idle("b2b");
        chk("b2b_first_cnt", n_first, 2);
        chk("b2b_am_rd_cnt", n_amrd, 5);
        chk("b2b_beats", beat_data_q.size(), 5);
        chk("b2b_rd_cnt", rd_addr_q.size(), 5);
        for (int k = 0; k < 5 && k < rd_addr_q.size(); k++)
            chk($sformatf("b2b_addr%0d", k), rd_addr_q[k], bb_addr[k]);
        for (int k = 0; k < 5 && k < beat_data_q.size(); k++) begin
            chk_data($sformatf("b2b_data%0d", k), beat_data_q[k], mk_data(bb_addr[k]));
            chk($sformatf("b2b_last%0d", k), beat_last_q[k], (k == 2 || k == 4) ? 1 : 0);
        end
        if (beat_cyc_q.size() == 5 && acc_q.size() == 2) begin
            chk("b2b_accept_after_tlast", (acc_q[1] > beat_cyc_q[2]) ? 1 : 0, 1);
            chk("b2b_gap_after_tlast", (beat_cyc_q[3] - beat_cyc_q[2] >= 2) ? 1 : 0, 1);
        end

        // reset during STREAM of a len=8 packet
        @(posedge clk);
        #1;
        clr_gen++;
        pat = 4'b1111;
        s_desc_valid = 1'b1; s_desc_head = 12'd0; s_desc_len = 12'd8;
        @(posedge clk);
        #1;
        s_desc_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (beat_data_q.size() < 4 && n < 100);
        chk("rst8_beats_before", beat_data_q.size(), 4);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
`ifdef PKT_RD_STATS_EN
        chk("rst8_stat_words_pre", stat_words, tot_beats);
        chk("rst8_stat_pkts_pre", stat_pkts, tot_pkts);
`endif
        @(negedge clk);
        chk("rst8_ready", s_desc_ready, 0);
        chk("rst8_strobes", {am_rd_en, am_first_word_en, buf_rd_en}, 0);
        chk("rst8_tvalid", m_axis_tvalid, 0);
        chk("rst8_tlast", m_axis_tlast, 0);
        chk("rst8_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
        chk("rst8_busy", busy, 0);
`ifdef PKT_RD_STATS_EN
        chk("rst8_stat_words_post", stat_words, 0);
        chk("rst8_stat_pkts_post", stat_pkts, 0);
`endif
        base_beats = tot_beats;
        base_pkts  = tot_pkts;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst8_ready_after", s_desc_ready, 1);
        run_vec(vecs[4], 7);
        run_vec(vecs[1], 8);
`ifdef PKT_RD_STATS_EN
        chk("end_stat_words", stat_words, tot_beats - base_beats);
        chk("end_stat_pkts", stat_pkts, tot_pkts - base_pkts);
`else
        chk("end_pkts_after_reset", tot_pkts - base_pkts, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
